fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 PCSrc  input  1  SHALL select the branch/jump target (1) or PC+4 (0) for the next PC.
REQ-005 PCTarget  input  32  SHALL be the redirect address, used when PCSrc=1.
REQ-006 stall  input  1  SHALL indicate that the downstream stage cannot consume the current instruction.
REQ-007 imemReq  output  1  SHALL be the instruction-memory read request.
REQ-008 imemAddr  output  32  SHALL be the fetch address, equal to PC.
REQ-009 imemAck  input  1  SHALL be the memory acknowledge; it is valid only while imemReq=1.
REQ-010 imemData  input  32  SHALL be the instruction word, sampled when imemReq&&imemAck.
REQ-011 instr  output  32  SHALL be the registered instruction word.
REQ-012 instrValid  output  1  SHALL indicate that instr, PC and the decode fields are valid.
REQ-013 PC  output  32  SHALL be the current program counter; PCPlus4  output  32  SHALL equal PC+4, modulo 2^32.
REQ-014 opcode  output  7  SHALL be instr[6:0]; funct3  output  3  SHALL be instr[14:12]; funct7  output  1  SHALL be instr[30]; these feed the control unit directly.
REQ-015 misalignErr  output  1  SHALL flag a misaligned redirect (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, VALID and ERR.
REQ-017 IDLE: one cycle after reset deasserts, the FSM SHALL move to REQ unconditionally.
REQ-018 REQ: imemReq=1 and imemAddr=PC; on imemReq&&imemAck, instr<=imemData, instrValid<=1, and the FSM moves to VALID; otherwise it stays in REQ and holds the request.
REQ-019 VALID with stall=1: instr, PC and instrValid SHALL hold, and imemReq SHALL be 0.
REQ-020 VALID with stall=0: PC<=PCSrc?PCTarget:PC+4, instrValid<=0, and the FSM moves to REQ.
REQ-021 PCSrc and PCTarget SHALL be sampled only in VALID with stall=0; they are ignored in all other states.
REQ-022 imemAck asserted outside REQ SHALL be ignored.
REQ-023 Minimum throughput is one instruction per 2 cycles; each extra wait cycle on imemAck adds one cycle.
REQ-024 PC+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-025 imemAck and stall in the same cycle: no conflict exists, because they are valid in different states; the REQ/VALID rules apply independently.

Reset
REQ-026 On a reset=1 edge: PC=RESET_PC, instr=32'h0000_0013 (NOP), instrValid=0, imemReq=0, misalignErr=0, and the FSM goes to IDLE.
REQ-027 Reset during REQ or VALID SHALL abort the pending request; an imemAck on the reset edge SHALL NOT load instr.
REQ-028 Reset SHALL take priority over every other input.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHECK_EN defined: a redirect with PCTarget[1:0]!=2'b00 SHALL move the FSM to ERR.
REQ-030 In ERR: misalignErr=1, imemReq=0 and instrValid=0; PC SHALL hold the offending target; ERR SHALL be exited only by reset.
REQ-031 Macro FETCH_MISALIGN_CHECK_EN undefined: PCTarget[1:0] SHALL be forced to 2'b00, misalignErr SHALL be tied 0, and the ERR state SHALL NOT be implemented.

Verification
REQ-032 Reset, then imemAck=1 with imemData=32'h0000_0003 in the first REQ cycle -> PC=0, instrValid=1, opcode=7'b0000011 two cycles after reset release.
REQ-033 VALID with stall=0, PCSrc=0 on PC=0 -> next imemAddr=32'h4; with PCSrc=1 and PCTarget=32'h100 -> imemAddr=32'h100.
REQ-034 imemAck delayed 3 cycles -> imemReq stays 1 and imemAddr stays stable; instr loads on the ack edge only.
REQ-035 stall=1 for 4 cycles in VALID with instr=32'h0000_0063 -> instr, PC and instrValid unchanged and imemReq=0; stall=0 -> fetch resumes at PC+4.
REQ-036 Reset asserted in REQ with imemAck=1 -> instr=32'h0000_0013, instrValid=0, PC=RESET_PC.
REQ-037 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> misalignErr=1 and no further imemReq; without it -> imemAddr=32'h100.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect/stall controls from the pipeline, the
// instruction-memory request/acknowledge pair, and the decoded outputs.
// The master modport is the fetch unit's view; the slave modport is the
// view of the surrounding pipeline and instruction memory.
interface fetch_unit_if;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic        misalignErr;

  modport master (
    input  PCSrc, PCTarget, stall, imemAck, imemData,
    output imemReq, imemAddr, instr, instrValid, PC, PCPlus4,
           opcode, funct3, funct7, misalignErr
  );

  modport slave (
    output PCSrc, PCTarget, stall, imemAck, imemData,
    input  imemReq, imemAddr, instr, instrValid, PC, PCPlus4,
           opcode, funct3, funct7, misalignErr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read
// per instruction, registers the returned word and exposes its decode fields.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target traps into a sticky ERR state (left only by
// reset); when undefined, the target's low two bits are dropped instead.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    ERR   = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state, next-PC and instruction capture for the fetch sequence.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        // The acknowledge only means something while the request is up.
        if (bus.imemAck) begin
          instr_d = bus.imemData;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        // Redirect controls are consumed only on the cycle the instruction leaves.
        if (!bus.stall) begin
          valid_d = 1'b0;
          state_d = REQ;
          if (bus.PCSrc) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_d = bus.PCTarget;
            if (bus.PCTarget[1:0] != 2'b00) begin
              state_d = ERR;
            end
`else
            pc_d = {bus.PCTarget[31:2], 2'b00};
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ERR: begin
        // Sticky trap: PC keeps the offending target for inspection.
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over every other input, including an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imemReq    = (state_q == REQ);
  assign bus.imemAddr   = pc_q;
  assign bus.instr      = instr_q;
  assign bus.instrValid = valid_q;
  assign bus.PC         = pc_q;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.opcode     = instr_q[6:0];
  assign bus.funct3     = instr_q[14:12];
  assign bus.funct7     = instr_q[30];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.misalignErr = (state_q == ERR);
`else
  assign bus.misalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: transaction-level reference model of the fetch
// sequence (expected PC and instruction per fetched word) with randomized
// acknowledge delays, stall lengths, redirects and ignored-input noise.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decoded outputs must always follow the model's instruction word.
  task automatic chk_fields();
    chk("instr",   bus.instr, exp_instr);
    chk("opcode",  {25'd0, bus.opcode}, {25'd0, exp_instr[6:0]});
    chk("funct3",  {29'd0, bus.funct3}, {29'd0, exp_instr[14:12]});
    chk("funct7",  {31'd0, bus.funct7}, {31'd0, exp_instr[30]});
    chk("pc",      bus.PC, exp_pc);
    chk("pcplus4", bus.PCPlus4, exp_pc + 32'd4);
  endtask

  // One complete fetch starting with the unit in its request state:
  // ack after 'delay' cycles, hold for 'stalls' cycles, then leave with
  // the given redirect choice. Non-aligned targets are only passed here
  // in builds without the misalignment trap.
  task automatic fetch_one(input int delay, input logic [31:0] data, input int stalls,
                           input logic src, input logic [31:0] tgt);
    bus.imemAck = 1'b0;
    for (int i = 0; i < delay; i++) begin
      chk("wait_req",   {31'd0, bus.imemReq}, 32'd1);
      chk("wait_addr",  bus.imemAddr, exp_pc);
      chk("wait_valid", {31'd0, bus.instrValid}, 32'd0);
      bus.stall    = 1'($urandom);
      bus.PCSrc    = 1'b1;
      bus.PCTarget = $urandom;
      bus.imemData = $urandom;
      step();
    end
    chk("req",  {31'd0, bus.imemReq}, 32'd1);
    chk("addr", bus.imemAddr, exp_pc);
    bus.imemAck  = 1'b1;
    bus.imemData = data;
    bus.stall    = 1'($urandom);
    step();
    exp_instr = data;
    chk("valid", {31'd0, bus.instrValid}, 32'd1);
    chk("req_in_valid", {31'd0, bus.imemReq}, 32'd0);
    chk_fields();
    for (int i = 0; i < stalls; i++) begin
      bus.stall    = 1'b1;
      bus.imemAck  = 1'($urandom);
      bus.imemData = $urandom;
      bus.PCSrc    = 1'($urandom);
      bus.PCTarget = $urandom;
      step();
      chk("stall_valid", {31'd0, bus.instrValid}, 32'd1);
      chk("stall_req",   {31'd0, bus.imemReq}, 32'd0);
      chk("stall_instr", bus.instr, exp_instr);
      chk("stall_pc",    bus.PC, exp_pc);
    end
    bus.stall    = 1'b0;
    bus.imemAck  = 1'b0;
    bus.PCSrc    = src;
    bus.PCTarget = tgt;
    step();
    exp_pc = src ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    bus.PCSrc    = 1'($urandom);
    bus.PCTarget = $urandom;
    chk("next_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("next_req",   {31'd0, bus.imemReq}, 32'd1);
    chk("next_addr",  bus.imemAddr, exp_pc);
    chk("next_err",   {31'd0, bus.misalignErr}, 32'd0);
  endtask

  initial begin
    logic [31:0] tgt;
    n_tests      = 0;
    n_fail       = 0;
    bus.PCSrc    = 1'b0;
    bus.PCTarget = 32'd0;
    bus.stall    = 1'b0;
    bus.imemAck  = 1'b1;
    bus.imemData = 32'hDEAD_BEEF;
    reset        = 1'b1;
    step();
    step();
    exp_pc    = RESET_PC;
    exp_instr = NOP;
    chk("rst_pc",    bus.PC, RESET_PC);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("rst_req",   {31'd0, bus.imemReq}, 32'd0);
    chk("rst_err",   {31'd0, bus.misalignErr}, 32'd0);

    // First cycle after release is IDLE; an ack there must be ignored.
    reset = 1'b0;
    step();
    bus.imemAck = 1'b0;
    chk("idle_ignores_ack", bus.instr, NOP);
    chk("first_req",  {31'd0, bus.imemReq}, 32'd1);
    chk("first_addr", bus.imemAddr, RESET_PC);

    // Immediate ack, sequential, then delayed ack with a long stall.
    fetch_one(0, 32'h0000_0003, 0, 1'b0, 32'd0);
    fetch_one(3, 32'h0000_0063, 4, 1'b0, 32'd0);
    fetch_one(0, 32'h4000_5033, 0, 1'b1, 32'h0000_0100);
    // Wrap of PC+4 at the top of the address space.
    fetch_one(1, 32'h0000_0013, 0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(0, 32'h0000_0013, 1, 1'b0, 32'd0);
    chk("wrap_pc", bus.PC, 32'h0000_0000);

    for (int n = 0; n < 40; n++) begin
      tgt = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      fetch_one(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
                1'($urandom), tgt);
    end

    // Reset in REQ with a coincident ack: the ack must not load instr.
    reset        = 1'b1;
    bus.imemAck  = 1'b1;
    bus.imemData = 32'h1234_5677;
    step();
    exp_pc    = RESET_PC;
    exp_instr = NOP;
    chk("rreq_instr", bus.instr, NOP);
    chk("rreq_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("rreq_pc",    bus.PC, RESET_PC);
    chk("rreq_req",   {31'd0, bus.imemReq}, 32'd0);
    reset       = 1'b0;
    bus.imemAck = 1'b0;
    step();
    chk("rreq_restart", {31'd0, bus.imemReq}, 32'd1);

    // Misaligned redirect.
    bus.imemAck  = 1'b1;
    bus.imemData = 32'h0000_006F;
    step();
    bus.imemAck  = 1'b0;
    bus.stall    = 1'b0;
    bus.PCSrc    = 1'b1;
    bus.PCTarget = 32'h0000_0102;
    step();
    bus.PCSrc = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      chk("err_flag",  {31'd0, bus.misalignErr}, 32'd1);
      chk("err_req",   {31'd0, bus.imemReq}, 32'd0);
      chk("err_valid", {31'd0, bus.instrValid}, 32'd0);
      chk("err_pc",    bus.PC, 32'h0000_0102);
      bus.imemAck = 1'b1;
      step();
    end
`else
    chk("mis_addr", bus.imemAddr, 32'h0000_0100);
    chk("mis_err",  {31'd0, bus.misalignErr}, 32'd0);
    chk("mis_req",  {31'd0, bus.imemReq}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
